// File: rtl/rr_pkg.sv
// Shared constants and FSM state encoding for the round-robin grant encoder.
package rr_pkg;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority search: first requester after ptr, wrapping,
// with ptr itself searched last.
module rr_pick
    import rr_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            cand = ptr + IDX_W'(i);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin grant FSM with registered binary grant index.
// Define RR_TIMEOUT_EN to force release after TIMEOUT_CYC grant cycles.
module rr_grant_encoder
    import rr_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             done,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             tout
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             expired;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef RR_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tout_q, tout_d;

    // cnt_q counts completed grant cycles; the last allowed one has cnt_q == TIMEOUT_CYC-1
    assign expired = (state_q == GRANT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign tout    = tout_q;

    always_comb begin
        cnt_d  = '0;
        tout_d = 1'b0;
        if (state_q == GRANT) begin
            if (done || !req[gnt_idx_q] || expired) begin
                tout_d = expired && !done && req[gnt_idx_q];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= tout_d;
        end
    end
`else
    assign expired = 1'b0;
    assign tout    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        unique case (state_q)
            IDLE: begin
                gnt_vld_d = 1'b0;
                if (pick_any) begin
                    gnt_idx_d = pick_idx;
                    gnt_vld_d = 1'b1;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                // Release never re-arbitrates: the IDLE bubble is mandatory
                if (done || !req[gnt_idx_q] || expired) begin
                    gnt_vld_d = 1'b0;
                    ptr_d     = gnt_idx_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '1;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
        end
    end

    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed, table-driven bench for rr_grant_encoder; the timeout sequence
// follows whichever build (RR_TIMEOUT_EN defined or not) is compiled.
module tb_rr_grant_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       tout;

    int n_vec = 0;
    int n_bad = 0;

    rr_grant_encoder #(.TIMEOUT_CYC(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .tout    (tout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic       vld;
        logic [1:0] idx;
        logic       tout;
    } vec_t;

    localparam int NV = 33;
    vec_t tbl [NV];

    task automatic check(input string name, input int row, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, exp);
        end
    endtask

    // Drive away from the active edge, then sample just after it
    task automatic step(input logic r, input logic [3:0] q, input logic d);
        @(negedge clk);
        rst  = r;
        req  = q;
        done = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           rst  req      done  vld   idx    tout
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0}; // reset
        tbl[1]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 2'd0, 1'b0}; // ptr=3 -> ch0
        tbl[2]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[3]  = '{1'b0, 4'b0101, 1'b1, 1'b0, 2'd0, 1'b0}; // done release
        tbl[4]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 2'd2, 1'b0}; // ch2 after bubble
        tbl[5]  = '{1'b0, 4'b0101, 1'b1, 1'b0, 2'd2, 1'b0};
        tbl[6]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd3, 1'b0}; // all request
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd3, 1'b0};
        tbl[8]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[9]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[10] = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd1, 1'b0};
        tbl[11] = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b0};
        tbl[12] = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd2, 1'b0};
        tbl[13] = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd2, 1'b0};
        tbl[14] = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd3, 1'b0};
        tbl[15] = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd3, 1'b0};
        tbl[16] = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[17] = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[18] = '{1'b0, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0}; // ch3 granted
        tbl[19] = '{1'b0, 4'b1001, 1'b1, 1'b0, 2'd3, 1'b0}; // done wins over new req
        tbl[20] = '{1'b0, 4'b1001, 1'b0, 1'b1, 2'd0, 1'b0}; // wrap 3 -> 0
        tbl[21] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0}; // req drop release
        tbl[22] = '{1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0}; // ch1 granted
        tbl[23] = '{1'b0, 4'b0101, 1'b0, 1'b0, 2'd1, 1'b0}; // req[1] drops
        tbl[24] = '{1'b0, 4'b0101, 1'b0, 1'b1, 2'd2, 1'b0}; // ptr=1 -> ch2 first
        tbl[25] = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd2, 1'b0}; // others ignored
        tbl[26] = '{1'b1, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0}; // reset mid-grant
        tbl[27] = '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0};
        tbl[28] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[29] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0}; // idle, no req
        tbl[30] = '{1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0};
        tbl[31] = '{1'b0, 4'b0010, 1'b1, 1'b0, 2'd1, 1'b0};
        tbl[32] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0}; // idx holds in idle

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].done);
            check("gnt_vld", i, {1'b0, gnt_vld}, {1'b0, tbl[i].vld});
            check("gnt_idx", i, gnt_idx, tbl[i].idx);
            check("tout",    i, {1'b0, tout},    {1'b0, tbl[i].tout});
        end

        // Long hold on ch0 with done low (state: IDLE, ptr=1)
        for (int k = 1; k <= 12; k++) begin
            logic ev, et;
            step(1'b0, 4'b0001, 1'b0);
`ifdef RR_TIMEOUT_EN
            ev = (k <= 8) || (k >= 10);
            et = (k == 9);
`else
            ev = 1'b1;
            et = 1'b0;
`endif
            check("hold_vld",  100 + k, {1'b0, gnt_vld}, {1'b0, ev});
            check("hold_tout", 100 + k, {1'b0, tout},    {1'b0, et});
            check("hold_idx",  100 + k, gnt_idx, 2'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_grant_encoder.md
RR_GRANT_ENCODER -- requirements
Module: rr_grant_encoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 8: the maximum number of grant cycles before forced release; it is used only when RR_TIMEOUT_EN is defined.
REQ-002 SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port req, input, 4 bits: per-channel request, with bit i for channel i.
REQ-006 SHALL have port done, input, 1 bit: current owner releases its grant.
REQ-007 SHALL have port gnt_idx, output, 2 bits: binary index of the granted channel; this is the encoded select fed to the downstream 2-to-4 decoder.
REQ-008 SHALL have port gnt_vld, output, 1 bit: gnt_idx is a valid, live grant.
REQ-009 SHALL have port tout, output, 1 bit: one-cycle pulse on a forced timeout release.

Function
REQ-010 SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-011 IDLE: if req is not 0, SHALL pick a channel by rotating priority starting at (ptr+1) mod 4, wrapping 3->0.
- On the pick, it SHALL register gnt_idx, set gnt_vld=1 and enter GRANT on the same edge.
REQ-012 Latency: SHALL assert gnt_vld exactly one clock after the edge at which req was sampled non-zero in IDLE.
REQ-013 IDLE with req=0: SHALL remain in IDLE, gnt_vld=0, and gnt_idx holds its last value.
REQ-014 GRANT: gnt_idx SHALL stay stable, and changes on req for other channels SHALL be ignored.
REQ-015 GRANT release SHALL occur when done=1 or req[gnt_idx]=0.
- On release, next edge: gnt_vld=0, ptr<=gnt_idx, state<=IDLE.
REQ-016 SHALL insert one mandatory IDLE bubble cycle between consecutive grants, so gnt_vld is never high for two different owners back to back.
REQ-017 If done and a new req arrive together in GRANT, release SHALL take precedence; the new req is arbitrated in the following IDLE cycle.
REQ-018 A channel that just released SHALL have lowest priority in the next arbitration (ptr update).
REQ-019 ptr SHALL be 2 bits and wrap modulo 4 naturally; no other arithmetic is exposed.

Reset
REQ-020 rst=1 at a clock edge SHALL force state=IDLE, ptr=3 (so channel 0 has first priority), gnt_idx=0, gnt_vld=0, tout=0, and timeout counter=0.
REQ-021 rst asserted mid-GRANT SHALL drop gnt_vld on that same edge, with no release side effects on ptr other than the reset value.
REQ-022 rst SHALL take precedence over all other inputs.

Configuration
REQ-023 Macro RR_TIMEOUT_EN defined: a grant-cycle counter SHALL run in GRANT.
- When gnt_vld has been high for TIMEOUT_CYC cycles without release, it SHALL force a release as in REQ-015 and pulse tout=1 for one cycle.
- The counter SHALL clear on every entry to IDLE.
REQ-024 Macro RR_TIMEOUT_EN undefined: the SHALL tie tout to 0, include no counter logic, and hold a grant indefinitely until done or request drop.

Structure
REQ-025 Shared package rr_pkg SHALL hold: N_CH=4, IDX_W=2, and the FSM state encoding (IDLE=0, GRANT=1).
REQ-026 SHALL contain one combinational sub-module rr_pick(req, ptr -> idx, any) implementing the rotating-priority search; all state SHALL live in the top module.

Verification
REQ-027 Reset then req=4'b0101 held: gnt_vld rises one clock later with gnt_idx=0; after done, gnt_idx=2 is granted following one idle cycle.
REQ-028 req=4'b1111 with done pulsed on every grant: grant order SHALL be 0,1,2,3,0, and gnt_vld low for exactly one cycle between grants.
REQ-029 Channel 3 granted, then req=4'b1001 and done=1 on the same cycle: release, one idle cycle, then gnt_idx=0 (wrap-around from ptr=3).
REQ-030 Channel 1 granted, req[1] drops to 0 with done=0: gnt_vld=0 on the next edge; ptr=1 so channel 2 has next priority.
REQ-031 rst=1 asserted mid-GRANT with gnt_idx=2: next edge gnt_vld=0 and gnt_idx=0; with req=4'b0100 after reset release, channel 2 is granted.
REQ-032 RR_TIMEOUT_EN defined, TIMEOUT_CYC=8, req[0] held, done=0: gnt_vld high for exactly 8 cycles, tout=1 for one cycle, then re-arbitration; without the macro, tout stays 0 and gnt_vld stays high.
